// File: rtl/accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : accumulator_pkg
//  Description : Shared types for the batch accumulator (state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package accumulator_pkg;

    // Two-state batch controller: collecting samples, or holding a result.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

endpackage : accumulator_pkg
`default_nettype wire

// File: rtl/adder_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : adder_nbit
//  Description : Combinational n-bit ripple-carry adder built from a chain of
//                full-adder cells. Produces the truncated sum and carry-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_nbit #(
    parameter int NUMB_BITS = 8
) (
    input  logic [NUMB_BITS-1:0] i_a,
    input  logic [NUMB_BITS-1:0] i_b,
    input  logic                 i_carry_in,
    output logic [NUMB_BITS-1:0] o_sum,
    output logic                 o_carry_out
);

    // Carry chain: w_carry[i] enters bit i, w_carry[NUMB_BITS] leaves the MSB.
    logic [NUMB_BITS:0] w_carry;

    assign w_carry[0] = i_carry_in;

    // One full-adder cell per bit position.
    for (genvar i = 0; i < NUMB_BITS; i++) begin : g_bit
        logic w_prop;
        assign w_prop         = i_a[i] ^ i_b[i];
        assign o_sum[i]       = w_prop ^ w_carry[i];
        assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & w_prop);
    end

    assign o_carry_out = w_carry[NUMB_BITS];

endmodule : adder_nbit
`default_nettype wire

// File: rtl/accumulator_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_nbit
//  Description : Batch accumulator. Sums exactly NUM_SAMPLES unsigned samples
//                received over a valid/ready handshake through the ripple
//                adder, then offers the truncated sum and a sticky overflow
//                flag over a second valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module accumulator_nbit #(
    parameter int NUMB_BITS   = 8,
    parameter int NUM_SAMPLES = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUMB_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUMB_BITS-1:0] out_sum,
    output logic                 out_overflow
);

    import accumulator_pkg::*;

    // Counter must be able to hold NUM_SAMPLES itself.
    localparam int                 c_CNT_W    = $clog2(NUM_SAMPLES + 1);
    // Count value before the accept that completes a batch.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NUM_SAMPLES - 1);

    acc_state_t           r_state;
    acc_state_t           w_next_state;
    logic [NUMB_BITS-1:0] r_acc;
    logic                 r_ovf;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [NUMB_BITS-1:0] w_sum;
    logic                 w_carry_out;
    logic                 w_accept;
    logic                 w_release;
    logic                 w_flush;

    // Operand a is the running total, b the incoming sample; no carry-in.
    adder_nbit #(
        .NUMB_BITS (NUMB_BITS)
    ) u_adder (
        .i_a         (r_acc),
        .i_b         (in_data),
        .i_carry_in  (1'b0),
        .o_sum       (w_sum),
        .o_carry_out (w_carry_out)
    );

    // Handshake qualifiers are derived from state, never from the outputs,
    // so no input-to-output combinational path exists.
    assign w_accept  = in_valid  && (r_state == ACCUM);
    assign w_release = out_ready && (r_state == DONE);
    // Either an abort or a completed output transfer empties the batch.
    assign w_flush   = clear || w_release;

    // State register; reset returns to collecting.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; clear overrides any accept or output transfer.
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = ACCUM;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept && (r_cnt == c_CNT_LAST)) begin
                        w_next_state = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_next_state = ACCUM;
                    end
                end
                default: w_next_state = ACCUM;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b1;
        endcase
    end

    // Batch datapath: reset/flush clears, an accepted sample adds in.
    always_ff @(posedge clk) begin
        if (!n_rst || w_flush) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_carry_out;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result is always driven from the registers; out_valid qualifies it.
    assign out_sum      = r_acc;
    assign out_overflow = r_ovf;

endmodule : accumulator_nbit
`default_nettype wire

// File: doc/accumulator_nbit.md
# accumulator_nbit

Batch accumulator that sits directly upstream of the result sink and wraps the team's ripple adder. It accepts a stream of unsigned NUMB_BITS-wide samples over a valid/ready handshake and sums exactly NUM_SAMPLES of them. It then presents the truncated sum and a sticky carry-out overflow flag over a second valid/ready handshake. It is the sequential front end that feeds operands and carry-in to the combinational n-bit adder and consumes its sum and carry-out.

## Interface
- NUMB_BITS, 8, sample and sum width; must be ≥ 1.
- NUM_SAMPLES, 4, samples per batch; must be ≥ 1.

- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- clear  input  1  synchronous batch abort.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  NUMB_BITS  unsigned sample.
- out_valid  output  1  out_sum and out_overflow are valid.
- out_ready  input  1  downstream consumes the result this cycle.
- out_sum  output  NUMB_BITS  batch sum modulo 2^NUMB_BITS.
- out_overflow  output  1  high if any addition in the batch produced a carry-out.

## Operation
- State machine with two states:
  - ACCUM: in_ready = 1, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Registers:
  - acc (NUMB_BITS wide).
  - ovf (1 bit).
  - cnt ($clog2(NUM_SAMPLES+1) bits).
- Adder operands:
  - a = acc, b = in_data, carry_in = 0.
  - The adder is used only on an accepted sample.
- Accept condition: an input transfer occurs when in_valid && in_ready.
- On accept in ACCUM:
  - acc ← adder sum, truncated to NUMB_BITS (wrap-around).
  - ovf ← ovf | adder carry-out.
  - cnt ← cnt + 1.
- Batch completion: if the accept takes cnt from NUM_SAMPLES−1 to NUM_SAMPLES, the next state is DONE.
- No accept: in_valid low in ACCUM leaves acc, ovf and cnt unchanged. Gaps are allowed.
- DONE:
  - out_sum = acc and out_overflow = ovf, held stable while out_ready is low.
  - When out_ready is high: next state is ACCUM and acc, ovf and cnt are cleared to 0.
- clear:
  - When high, in any state: next state is ACCUM and acc, ovf and cnt are cleared to 0.
  - clear has priority over an input accept and over an output transfer in the same cycle. That sample or result is dropped.
- n_rst low: same effect as clear and has priority over everything, including clear.
- out_sum and out_overflow are driven from acc and ovf in all states. They are qualified only by out_valid.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0.
  - out_sum = 0.
  - out_overflow = 0.
- Output decode: in_ready and out_valid are pure decodes of state. There is no combinational path from in_valid or out_ready to any output.
- Input latency: a sample accepted at edge k is reflected in acc, and therefore out_sum, after edge k.
- Result latency: the Nth accept at edge k raises out_valid after edge k.
- Minimum batch period: NUM_SAMPLES + 1 cycles. This is N accept cycles plus one DONE cycle with out_ready high.
- Back-to-back batches: in_ready returns to 1 the cycle after the output transfer.
- NUM_SAMPLES = 1: every accepted sample moves the block to DONE. out_sum equals the sample and out_overflow = 0.
- Reset mid-batch or mid-DONE: the partial sum and any pending result are discarded. Outputs take their reset values after the edge.

## Structure
- Shared package accumulator_pkg holds:
  - typedef enum logic {ACCUM, DONE} acc_state_t.
- Sub-module: one instance of adder_nbit, with NUMB_BITS passed through.
- Top-level logic: the state register, acc/ovf/cnt registers and next-state logic stay in accumulator_nbit.

## Test plan
All scenarios use NUMB_BITS = 8, NUM_SAMPLES = 4.
- Basic batch: send 10, 20, 30, 40 with in_valid continuously high and out_ready high. Expected: out_valid rises the cycle after the 4th accept, out_sum = 100, out_overflow = 0, and in_ready = 1 again the next cycle.
- Wrap and sticky overflow: send 100, 100, 100, 0. Expected: out_sum = 44 (300 mod 256) and out_overflow = 1, still set after the final 0 add.
- Backpressure: hold out_ready low for 5 cycles in DONE while in_valid stays high. Expected: out_sum and out_overflow stay stable, in_ready = 0, and no sample is accepted. Raising out_ready completes the transfer.
- Input gaps: send 1, gap 3 cycles, 2, gap, 3, 4. Expected: out_sum = 10, and cnt and acc are unchanged during gaps.
- clear collision: after 2 samples (5, 6), assert clear together with in_valid (data 7), then send 1, 1, 1, 1. Expected: 7 is dropped and out_sum = 4. Separately, clear with out_ready high in DONE drops the result and out_valid falls.
- Reset mid-batch: drive n_rst low for 1 cycle after 3 samples. Expected: outputs take reset values (out_sum = 0, in_ready = 1), and the next 4 samples of 2 give out_sum = 8.
